// File: rtl/cpx_dot_prod_acc_if.sv
`default_nettype none
// ============================================================================
// Module      : cpx_dot_prod_acc_if
// Description : Sample-in / result-out bundle for the complex dot-product
//               accumulator. The slave modport is the engine side, the
//               master modport is the sample source / result consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpx_dot_prod_acc_if #(
    parameter int X_BITS   = 12,
    parameter int Y_BITS   = 12,
    parameter int LEN_BITS = 8,
    parameter int OUT_BITS = 24
) ();
    logic [LEN_BITS-1:0]        dot_len;
    logic                       conj;
    logic                       m_axis_x_tvalid;
    logic signed [X_BITS-1:0]   xi;
    logic signed [X_BITS-1:0]   xq;
    logic                       m_axis_y_tvalid;
    logic signed [Y_BITS-1:0]   yi;
    logic signed [Y_BITS-1:0]   yq;
    logic                       m_axis_tready;
    logic                       s_axis_product_tvalid;
    logic                       s_axis_product_tready;
    logic signed [OUT_BITS-1:0] i;
    logic signed [OUT_BITS-1:0] q;
    logic                       sat_flag;

    modport slave (
        input  dot_len, conj,
        input  m_axis_x_tvalid, xi, xq,
        input  m_axis_y_tvalid, yi, yq,
        output m_axis_tready,
        output s_axis_product_tvalid,
        input  s_axis_product_tready,
        output i, q, sat_flag
    );

    modport master (
        output dot_len, conj,
        output m_axis_x_tvalid, xi, xq,
        output m_axis_y_tvalid, yi, yq,
        input  m_axis_tready,
        input  s_axis_product_tvalid,
        output s_axis_product_tready,
        input  i, q, sat_flag
    );
endinterface
`default_nettype wire

// File: rtl/cpx_dot_prod_acc.sv
`default_nettype none
// ============================================================================
// Module      : cpx_dot_prod_acc
// Description : Streaming complex dot product. Registers each accepted sample
//               pair, forms the four partial products, combines them into a
//               complex product (optionally against conj(y)), accumulates a
//               run-time length vector and emits one rounded, saturated
//               complex result per vector with full output backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module cpx_dot_prod_acc #(
    parameter int X_BITS    = 12,
    parameter int Y_BITS    = 12,
    parameter int LEN_BITS  = 8,
    parameter int ACC_BITS  = 40,
    parameter int OUT_BITS  = 24,
    parameter int OUT_SHIFT = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    cpx_dot_prod_acc_if.slave bus
);
    localparam int c_PW = X_BITS + Y_BITS;  // partial product width
    localparam int c_SW = ACC_BITS + 1;     // acc + product sum width
    localparam int c_RW = ACC_BITS + 2;     // headroom for the rounding add

    localparam logic signed [c_RW-1:0] c_RND =
        (OUT_SHIFT > 0) ? (c_RW'(1) <<< ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : '0;
    localparam logic signed [c_RW-1:0] c_MAX = (c_RW'(1) <<< (OUT_BITS - 1)) - c_RW'(1);
    localparam logic signed [c_RW-1:0] c_MIN = -(c_RW'(1) <<< (OUT_BITS - 1));

    // Round half toward +inf, shift, clamp. Bit OUT_BITS flags a clamp.
    function automatic logic [OUT_BITS:0] f_format(input logic signed [c_SW-1:0] s);
        logic signed [c_RW-1:0] r;
        logic signed [c_RW-1:0] v;
        logic                   clip;
        r    = (c_RW'(s) + c_RND) >>> OUT_SHIFT;
        v    = r;
        clip = 1'b0;
        if (r > c_MAX) begin
            v    = c_MAX;
            clip = 1'b1;
        end else if (r < c_MIN) begin
            v    = c_MIN;
            clip = 1'b1;
        end
        return {clip, v[OUT_BITS-1:0]};
    endfunction

    // Element counter and per-vector latched settings
    logic [LEN_BITS-1:0] r_cnt;
    logic [LEN_BITS-1:0] r_len;
    logic                r_conj;

    // S0: registered input sample pair
    logic                     r_s0_v, r_s0_last, r_s0_conj;
    logic signed [X_BITS-1:0] r_s0_xi, r_s0_xq;
    logic signed [Y_BITS-1:0] r_s0_yi, r_s0_yq;

    // S1: partial products
    logic                   r_s1_v, r_s1_last, r_s1_conj;
    logic signed [c_PW-1:0] r_s1_ii, r_s1_qq, r_s1_iq, r_s1_qi;

    // S2: complex product
    logic                       r_s2_v, r_s2_last;
    logic signed [ACC_BITS-1:0] r_s2_re, r_s2_im;

    // S3: accumulator and output register
    logic signed [ACC_BITS-1:0] r_acc_re, r_acc_im;
    logic                       r_out_v;
    logic signed [OUT_BITS-1:0] r_out_i, r_out_q;
    logic                       r_sat;

    logic                       w_en;
    logic                       w_accept;
    logic                       w_first;
    logic [LEN_BITS-1:0]        w_len_in;
    logic [LEN_BITS-1:0]        w_len_eff;
    logic                       w_conj;
    logic                       w_last;
    logic signed [c_PW-1:0]     w_ii, w_qq, w_iq, w_qi;
    logic signed [ACC_BITS-1:0] w_re, w_im;
    logic signed [c_SW-1:0]     w_sum_re, w_sum_im;
    logic [OUT_BITS:0]          w_fmt_re, w_fmt_im;
    logic                       w_load;

    // Stall control, accept decode and per-vector length/conj selection
    always_comb begin
        w_en      = ~(r_out_v & ~bus.s_axis_product_tready);
        w_accept  = bus.m_axis_x_tvalid & bus.m_axis_y_tvalid & w_en;
        w_first   = (r_cnt == '0);
        w_len_in  = (bus.dot_len == '0) ? LEN_BITS'(1) : bus.dot_len;
        w_len_eff = w_first ? w_len_in : r_len;
        w_conj    = w_first ? bus.conj : r_conj;
        w_last    = (r_cnt == (w_len_eff - LEN_BITS'(1)));
    end

    // Element counter; length and conj are captured on the first element
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_len  <= '0;
            r_conj <= 1'b0;
        end else if (w_accept) begin
            if (w_first) begin
                r_len  <= w_len_eff;
                r_conj <= bus.conj;
            end
            r_cnt <= w_last ? '0 : r_cnt + LEN_BITS'(1);
        end
    end

    // S0: register the accepted sample pair with its tags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0_v    <= 1'b0;
            r_s0_last <= 1'b0;
            r_s0_conj <= 1'b0;
            r_s0_xi   <= '0;
            r_s0_xq   <= '0;
            r_s0_yi   <= '0;
            r_s0_yq   <= '0;
        end else if (w_en) begin
            r_s0_v    <= w_accept;
            r_s0_last <= w_last;
            r_s0_conj <= w_conj;
            r_s0_xi   <= bus.xi;
            r_s0_xq   <= bus.xq;
            r_s0_yi   <= bus.yi;
            r_s0_yq   <= bus.yq;
        end
    end

    // Partial products at full product width
    always_comb begin
        w_ii = c_PW'(r_s0_xi) * c_PW'(r_s0_yi);
        w_qq = c_PW'(r_s0_xq) * c_PW'(r_s0_yq);
        w_iq = c_PW'(r_s0_xi) * c_PW'(r_s0_yq);
        w_qi = c_PW'(r_s0_xq) * c_PW'(r_s0_yi);
    end

    // S1: register the partial products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v    <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_conj <= 1'b0;
            r_s1_ii   <= '0;
            r_s1_qq   <= '0;
            r_s1_iq   <= '0;
            r_s1_qi   <= '0;
        end else if (w_en) begin
            r_s1_v    <= r_s0_v;
            r_s1_last <= r_s0_last;
            r_s1_conj <= r_s0_conj;
            r_s1_ii   <= w_ii;
            r_s1_qq   <= w_qq;
            r_s1_iq   <= w_iq;
            r_s1_qi   <= w_qi;
        end
    end

    // Combine partial products into x*y or x*conj(y) at accumulator width
    always_comb begin
        if (r_s1_conj) begin
            w_re = ACC_BITS'(r_s1_ii) + ACC_BITS'(r_s1_qq);
            w_im = ACC_BITS'(r_s1_qi) - ACC_BITS'(r_s1_iq);
        end else begin
            w_re = ACC_BITS'(r_s1_ii) - ACC_BITS'(r_s1_qq);
            w_im = ACC_BITS'(r_s1_iq) + ACC_BITS'(r_s1_qi);
        end
    end

    // S2: register the complex product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v    <= 1'b0;
            r_s2_last <= 1'b0;
            r_s2_re   <= '0;
            r_s2_im   <= '0;
        end else if (w_en) begin
            r_s2_v    <= r_s1_v;
            r_s2_last <= r_s1_last;
            r_s2_re   <= w_re;
            r_s2_im   <= w_im;
        end
    end

    // Running sum including the current element, and its output format
    always_comb begin
        w_sum_re = c_SW'(r_acc_re) + c_SW'(r_s2_re);
        w_sum_im = c_SW'(r_acc_im) + c_SW'(r_s2_im);
        w_fmt_re = f_format(w_sum_re);
        w_fmt_im = f_format(w_sum_im);
        w_load   = w_en & r_s2_v & r_s2_last;
    end

    // S3: accumulate; the last element of a vector loads the result and clears acc
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_re <= '0;
            r_acc_im <= '0;
            r_out_i  <= '0;
            r_out_q  <= '0;
            r_sat    <= 1'b0;
        end else if (w_en && r_s2_v) begin
            if (r_s2_last) begin
                r_acc_re <= '0;
                r_acc_im <= '0;
                r_out_i  <= w_fmt_re[OUT_BITS-1:0];
                r_out_q  <= w_fmt_im[OUT_BITS-1:0];
                if (w_fmt_re[OUT_BITS] || w_fmt_im[OUT_BITS]) begin
                    r_sat <= 1'b1;
                end
            end else begin
                r_acc_re <= w_sum_re[ACC_BITS-1:0];
                r_acc_im <= w_sum_im[ACC_BITS-1:0];
            end
        end
    end

    // Result valid: a load wins over a same-edge handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_v <= 1'b0;
        end else if (w_load) begin
            r_out_v <= 1'b1;
        end else if (r_out_v && bus.s_axis_product_tready) begin
            r_out_v <= 1'b0;
        end
    end

    assign bus.m_axis_tready         = w_en;
    assign bus.s_axis_product_tvalid = r_out_v;
    assign bus.i                     = r_out_i;
    assign bus.q                     = r_out_q;
    assign bus.sat_flag              = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_cpx_dot_prod_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpx_dot_prod_acc
// Description : Self-checking bench for cpx_dot_prod_acc. Two instances are
//               used: one with an 8-bit output shift, one with no shift for
//               clipping. A complex-arithmetic model predicts each result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpx_dot_prod_acc;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpx_dot_prod_acc_if #(.X_BITS(12), .Y_BITS(12), .LEN_BITS(8), .OUT_BITS(24)) u_if0 ();
    cpx_dot_prod_acc_if #(.X_BITS(12), .Y_BITS(12), .LEN_BITS(8), .OUT_BITS(24)) u_if1 ();

    cpx_dot_prod_acc #(.X_BITS(12), .Y_BITS(12), .LEN_BITS(8), .ACC_BITS(40),
                       .OUT_BITS(24), .OUT_SHIFT(8))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(u_if0));
    cpx_dot_prod_acc #(.X_BITS(12), .Y_BITS(12), .LEN_BITS(8), .ACC_BITS(40),
                       .OUT_BITS(24), .OUT_SHIFT(0))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        longint re;
        longint im;
        bit     sat;
    } res_t;

    res_t   exp0[$];
    res_t   exp1[$];
    int     m_cnt[2];
    int     m_len[2];
    bit     m_conj[2];
    longint m_re[2];
    longint m_im[2];
    bit     m_sat[2];
    bit     hold[2];
    longint hold_i[2];
    longint hold_q[2];
    int     cyc0 = 0;
    int     hs_cyc[$];
    longint hs_i[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_event(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event occurred, required none (t=%0t)", name, $time);
    endtask

    // Rounded (half toward +inf), shifted and clamped component
    function automatic longint fmt(input longint s, input int sh, output bit clip);
        longint r;
        r = s;
        if (sh > 0) r = (s + (longint'(1) << (sh - 1))) >>> sh;
        clip = 1'b0;
        if (r > 64'sd8388607)  begin r = 64'sd8388607;  clip = 1'b1; end
        if (r < -64'sd8388608) begin r = -64'sd8388608; clip = 1'b1; end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_len[k] = 1; m_conj[k] = 1'b0;
            m_re[k] = 0; m_im[k] = 0; m_sat[k] = 1'b0; hold[k] = 1'b0;
        end
        exp0.delete();
        exp1.delete();
    endtask

    // One accepted sample pair: complex multiply-accumulate over the vector
    task automatic model_accept(input int k, input longint xi, xq, yi, yq,
                                input int len, input bit cj);
        res_t e;
        bit   ci, cq;
        if (m_cnt[k] == 0) begin
            m_len[k]  = (len == 0) ? 1 : len;
            m_conj[k] = cj;
            m_re[k]   = 0;
            m_im[k]   = 0;
        end
        if (m_conj[k]) begin
            m_re[k] += xi * yi + xq * yq;
            m_im[k] += xq * yi - xi * yq;
        end else begin
            m_re[k] += xi * yi - xq * yq;
            m_im[k] += xi * yq + xq * yi;
        end
        m_cnt[k]++;
        if (m_cnt[k] == m_len[k]) begin
            e.re = fmt(m_re[k], (k == 0) ? 8 : 0, ci);
            e.im = fmt(m_im[k], (k == 0) ? 8 : 0, cq);
            m_sat[k] = m_sat[k] | ci | cq;
            e.sat = m_sat[k];
            if (k == 0) exp0.push_back(e); else exp1.push_back(e);
            m_cnt[k] = 0;
        end
    endtask

    // Per-cycle check of one instance, sampled on the falling edge
    task automatic observe(input int k, input logic xv, yv, mtr,
                           input logic signed [11:0] xi, xq, yi, yq,
                           input logic [7:0] len, input logic cj,
                           input logic pv, pr,
                           input logic signed [23:0] oi, oq, input logic sat,
                           input int cyc);
        res_t e;
        bit   have;
        chk($sformatf("tready_rule%0d", k), longint'(mtr), longint'(!(pv && !pr)));
        if (pv && !pr) begin
            if (hold[k]) begin
                chk($sformatf("stall_i%0d", k), longint'(oi), hold_i[k]);
                chk($sformatf("stall_q%0d", k), longint'(oq), hold_q[k]);
            end
            hold[k] = 1'b1; hold_i[k] = longint'(oi); hold_q[k] = longint'(oq);
        end else begin
            hold[k] = 1'b0;
        end
        if (xv && yv && mtr)
            model_accept(k, longint'(xi), longint'(xq), longint'(yi), longint'(yq), int'(len), cj);
        if (pv && pr) begin
            have = (k == 0) ? (exp0.size() > 0) : (exp1.size() > 0);
            if (!have) begin
                fail_event($sformatf("unexpected_result%0d", k));
            end else begin
                e = (k == 0) ? exp0.pop_front() : exp1.pop_front();
                chk($sformatf("res_i%0d", k), longint'(oi), e.re);
                chk($sformatf("res_q%0d", k), longint'(oq), e.im);
                chk($sformatf("res_sat%0d", k), longint'(sat), longint'(e.sat));
            end
            if (k == 0) begin
                hs_cyc.push_back(cyc);
                hs_i.push_back(longint'(oi));
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            observe(0, u_if0.m_axis_x_tvalid, u_if0.m_axis_y_tvalid, u_if0.m_axis_tready,
                    u_if0.xi, u_if0.xq, u_if0.yi, u_if0.yq, u_if0.dot_len, u_if0.conj,
                    u_if0.s_axis_product_tvalid, u_if0.s_axis_product_tready,
                    u_if0.i, u_if0.q, u_if0.sat_flag, cyc0);
            cyc0++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            observe(1, u_if1.m_axis_x_tvalid, u_if1.m_axis_y_tvalid, u_if1.m_axis_tready,
                    u_if1.xi, u_if1.xq, u_if1.yi, u_if1.yq, u_if1.dot_len, u_if1.conj,
                    u_if1.s_axis_product_tvalid, u_if1.s_axis_product_tready,
                    u_if1.i, u_if1.q, u_if1.sat_flag, 0);
        end
    end

    task automatic drive(input int k, input bit v, input int xi, xq, yi, yq, len, input bit cj);
        if (k == 0) begin
            u_if0.m_axis_x_tvalid = v; u_if0.m_axis_y_tvalid = v;
            u_if0.xi = 12'(xi); u_if0.xq = 12'(xq); u_if0.yi = 12'(yi); u_if0.yq = 12'(yq);
            u_if0.dot_len = 8'(len); u_if0.conj = cj;
        end else begin
            u_if1.m_axis_x_tvalid = v; u_if1.m_axis_y_tvalid = v;
            u_if1.xi = 12'(xi); u_if1.xq = 12'(xq); u_if1.yi = 12'(yi); u_if1.yq = 12'(yq);
            u_if1.dot_len = 8'(len); u_if1.conj = cj;
        end
    endtask

    task automatic idle(input int k);
        drive(k, 1'b0, 0, 0, 0, 0, 0, 1'b0);
    endtask

    // Present one pair and hold it until accepted; returns 1 ns after that edge
    task automatic send(input int k, input int xi, xq, yi, yq, len, input bit cj);
        bit done;
        done = 1'b0;
        drive(k, 1'b1, xi, xq, yi, yq, len, cj);
        for (int t = 0; t < 60 && !done; t++) begin
            @(negedge clk);
            done = (k == 0) ? u_if0.m_axis_tready : u_if1.m_axis_tready;
            @(posedge clk);
            #1;
        end
        if (!done) fail_event($sformatf("send_timeout%0d", k));
    endtask

    // Count falling edges until the result valid is seen (bounded)
    task automatic wait_valid(input int k, output int n);
        logic pv;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            pv = (k == 0) ? u_if0.s_axis_product_tvalid : u_if1.s_axis_product_tvalid;
        end while (!pv && n < 40);
        if (!pv) fail_event($sformatf("valid_timeout%0d", k));
    endtask

    initial begin
        int     n;
        longint i_held;

        idle(0);
        idle(1);
        u_if0.s_axis_product_tready = 1'b1;
        u_if1.s_axis_product_tready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", longint'(u_if0.s_axis_product_tvalid), 0);
        chk("rst_i", longint'(u_if0.i), 0);
        chk("rst_q", longint'(u_if0.q), 0);
        chk("rst_sat", longint'(u_if0.sat_flag), 0);
        chk("rst_tready", longint'(u_if0.m_axis_tready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Only one valid high: nothing may be accepted
        drive(0, 1'b0, 999, 999, 999, 999, 1, 1'b0);
        u_if0.m_axis_x_tvalid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        idle(0);

        // Normal mode with latency check
        for (int e = 0; e < 4; e++) send(0, 100, -50, 20, 30, 4, 1'b0);
        idle(0);
        wait_valid(0, n);
        chk("latency", n, 4);
        chk("norm_i", longint'(u_if0.i), 55);
        chk("norm_q", longint'(u_if0.q), 31);
        chk("norm_sat", longint'(u_if0.sat_flag), 0);
        @(posedge clk); #1;

        // Conjugate mode; later len/conj changes inside the vector are ignored
        send(0, 100, -50, 20, 30, 4, 1'b1);
        for (int e = 0; e < 3; e++) send(0, 100, -50, 20, 30, 7, 1'b0);
        idle(0);
        wait_valid(0, n);
        chk("conj_i", longint'(u_if0.i), 8);
        chk("conj_q", longint'(u_if0.q), -62);
        @(posedge clk); #1;

        // Back-to-back single-element vectors
        for (int k = 1; k <= 6; k++) send(0, 256, 0, k, 0, 1, 1'b0);
        idle(0);
        repeat (8) @(posedge clk);
        #1;
        n = hs_i.size();
        if (n < 6) begin
            fail_event("b2b_too_few_results");
        end else begin
            for (int j = 0; j < 6; j++) begin
                chk("b2b_i", hs_i[n-6+j], j + 1);
                if (j > 0) chk("b2b_gap", longint'(hs_cyc[n-6+j] - hs_cyc[n-7+j]), 1);
            end
        end

        // Backpressure: hold tready low for several cycles after a result
        u_if0.s_axis_product_tready = 1'b0;
        fork
            begin
                send(0, 3, -7, 11, 5, 2, 1'b0);
                send(0, -9, 4, 2, -8, 2, 1'b0);
                send(0, 50, 60, -70, 80, 2, 1'b0);
                send(0, 1, 1, 1, 1, 2, 1'b0);
                send(0, -2048, -2048, -2048, -2048, 2, 1'b0);
                send(0, 2047, -1, 5, 5, 2, 1'b0);
                idle(0);
            end
            begin
                int m;
                wait_valid(0, m);
                i_held = longint'(u_if0.i);
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    chk("bp_tready", longint'(u_if0.m_axis_tready), 0);
                    chk("bp_i_stable", longint'(u_if0.i), i_held);
                end
                @(posedge clk); #1;
                u_if0.s_axis_product_tready = 1'b1;
            end
        join
        repeat (12) @(posedge clk);
        #1;

        // Saturation on the unshifted instance; flag stays set afterwards
        for (int e = 0; e < 4; e++) send(1, 2047, 0, 2047, 0, 4, 1'b0);
        idle(1);
        wait_valid(1, n);
        chk("sat_i", longint'(u_if1.i), 8388607);
        chk("sat_q", longint'(u_if1.q), 0);
        chk("sat_flag", longint'(u_if1.sat_flag), 1);
        @(posedge clk); #1;
        for (int e = 0; e < 4; e++) send(1, 2047, 0, -2048, 0, 4, 1'b0);
        idle(1);
        wait_valid(1, n);
        chk("sat_neg_i", longint'(u_if1.i), -8388608);
        @(posedge clk); #1;
        send(1, 1, 0, 5, 0, 1, 1'b0);
        idle(1);
        wait_valid(1, n);
        chk("post_sat_i", longint'(u_if1.i), 5);
        chk("sat_sticky", longint'(u_if1.sat_flag), 1);
        @(posedge clk); #1;

        // Reset in the middle of a vector
        send(0, 100, -50, 20, 30, 4, 1'b0);
        send(0, 100, -50, 20, 30, 4, 1'b0);
        idle(0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_tvalid", longint'(u_if0.s_axis_product_tvalid), 0);
        chk("arst_i", longint'(u_if0.i), 0);
        chk("arst_q", longint'(u_if0.q), 0);
        chk("arst_tready", longint'(u_if0.m_axis_tready), 1);
        chk("arst_sat1", longint'(u_if1.sat_flag), 0);
        chk("arst_i1", longint'(u_if1.i), 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int e = 0; e < 4; e++) send(0, 100, -50, 20, 30, 4, 1'b0);
        idle(0);
        wait_valid(0, n);
        chk("after_rst_i", longint'(u_if0.i), 55);
        chk("after_rst_q", longint'(u_if0.q), 31);
        @(posedge clk); #1;

        repeat (5) @(posedge clk);
        #1;
        chk("drained0", longint'(exp0.size()), 0);
        chk("drained1", longint'(exp1.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
